seq_divider: RTL and testbench

- Iterative restoring (shift-subtract) unsigned divider. It is the inverse companion to the lab's ripple adders: addition builds sums, this block undoes multiplication by repeated conditional subtraction.
- Operands come from switch inputs. The block shows quotient, remainder and status on LEDs.
- It sits beside the adder instances in the board top and shares the single board clock.

---
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring (shift-subtract) unsigned divider, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_ZERO_DETECT_EN: zero divisor finishes after one cycle and raises div_by_zero.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] prem;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic             qbit;
  logic             short_cut;
  logic             accept;

  assign accept = (state == IDLE) && start;

  // One restoring step: a borrow out of the WIDTH+1 bit trial means restore.
  always_comb begin
    rem_sh   = {prem, dvd_reg[WIDTH-1]};
    trial    = rem_sh - {1'b0, dvs_reg};
    qbit     = ~trial[WIDTH];
    rem_next = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  end

`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
  logic zero_flag;

  assign short_cut = zero_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_flag   <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      zero_flag   <= (divisor == '0);
      div_by_zero <= 1'b0;
    end else if ((state == RUN) && zero_flag) begin
      div_by_zero <= 1'b1;
    end
  end
`else
  assign short_cut   = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      prem      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            dvd_reg <= dividend;
            dvs_reg <= divisor;
            prem    <= '0;
            count   <= CNT_W'(WIDTH - 1);
          end
        end
        RUN: begin
          if (short_cut) begin
            quotient  <= '1;
            remainder <= dvd_reg;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= FINISH;
          end else begin
            // Quotient bits shift into the vacated low end of the dividend register.
            dvd_reg <= {dvd_reg[WIDTH-2:0], qbit};
            prem    <= rem_next;
            count   <= count - CNT_W'(1);
            if (count == '0) begin
              quotient  <= {dvd_reg[WIDTH-2:0], qbit};
              remainder <= rem_next;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= FINISH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): driver queues expected results, monitor checks each done pulse.
module tb_seq_divider;

  localparam int W = 4;

`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
  localparam int ZLAT = 1;
  localparam bit ZFLAG = 1'b1;
`else
  localparam int ZLAT = 4;
  localparam bit ZFLAG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           when;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("div_by_zero", int'(div_by_zero), int'(e.z));
        check("done_cycle", cyc, e.when);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    e.q = q; e.r = r; e.z = z; e.when = cyc + lat;
    sb.push_back(e);
    check("busy_after_accept", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    reset = 1'b0;

    // Basic and boundary operands; busy is probed mid-operation.
    issue(4'd13, 4'd3, 4, 4'd4, 4'd1, 1'b0);
    @(posedge clk); #1;
    check("busy_mid", int'(busy), 1);
    drain();
    issue(4'd15, 4'd1, 4, 4'd15, 4'd0, 1'b0);  drain();
    issue(4'd2, 4'd7, 4, 4'd0, 4'd2, 1'b0);    drain();
    issue(4'd15, 4'd15, 4, 4'd1, 4'd0, 1'b0);  drain();
    issue(4'd0, 4'd5, 4, 4'd0, 4'd0, 1'b0);    drain();

    // Divide by zero, then a normal division clears the flag.
    issue(4'd9, 4'd0, ZLAT, 4'd15, 4'd9, ZFLAG);  drain();
    check("dbz_hold", int'(div_by_zero), int'(ZFLAG));
    issue(4'd6, 4'd4, 4, 4'd1, 4'd2, 1'b0);       drain();

    // Start while busy with changed operands is ignored.
    issue(4'd13, 4'd3, 4, 4'd4, 4'd1, 1'b0);
    start = 1'b1; dividend = 4'd8; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0; dividend = 4'd1; divisor = 4'd1;
    drain();
    repeat (6) @(negedge clk);
    check("idle_after_ignored_start", int'(busy), 0);

    // Reset two edges after acceptance discards the operation.
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_q", int'(quotient), 0);
    check("mid_rst_r", int'(remainder), 0);
    check("mid_rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    issue(4'd14, 4'd3, 4, 4'd4, 4'd2, 1'b0);  drain();

    // Held start: one accept every 6 cycles.
    begin
      exp_t e;
      int k;
      @(negedge clk);
      start = 1'b1; dividend = 4'd11; divisor = 4'd2;
      @(posedge clk); #1;
      k = cyc;
      for (int i = 0; i < 3; i++) begin
        e.q = 4'd5; e.r = 4'd1; e.z = 1'b0; e.when = k + 6 * i + 4;
        sb.push_back(e);
      end
      repeat (12) @(posedge clk);
      #1;
      check("b2b_third_accept_busy", int'(busy), 1);
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (8) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
